// File: rtl/ram_block_mover.sv
// Block copy/fill sequencer for the 8x11-bit two-read/one-write RAM, with memmove-style overlap handling.
// Optional write-back verification through read port 2 is enabled with `define RAM_BLOCK_MOVER_VERIFY_EN.
module ram_block_mover #(
    parameter int DATA_W = 11,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] Read_Data_1,
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
    input  logic [DATA_W-1:0] Read_Data_2,
    output logic [ADDR_W-1:0] Read_Address_2,
    output logic              verify_err,
`endif
    output logic [ADDR_W-1:0] Read_Address_1,
    output logic [DATA_W-1:0] Write_Data,
    output logic [ADDR_W-1:0] Write_Address,
    output logic              Write_Enable,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
    localparam logic [2:0] S_VERIFY = 3'd4;
`endif

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] STEP_UP = ADDR_W'(1);

    logic [2:0]        r_state;
    logic              r_mode;
    logic              r_desc;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_data_q;
    logic              r_err;
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
    logic [ADDR_W-1:0] r_vaddr;
    logic              r_verify_err;
`endif

    logic [ADDR_W-1:0] w_dist;
    logic [ADDR_W:0]   w_len_m1;
    logic              w_valid;
    logic              w_desc;
    logic [ADDR_W-1:0] w_src_start;
    logic [ADDR_W-1:0] w_dst_start;
    logic [ADDR_W-1:0] w_step;
    logic [DATA_W-1:0] w_wr_word;
    logic [2:0]        w_resume;

    // A full-ring copy onto a different base would overwrite its own unread source.
    assign w_dist      = dst_base - src_base;
    assign w_len_m1    = length - ONE_L;
    assign w_valid     = (length != '0) && (length <= DEPTH_L)
                         && !(!mode && (length == DEPTH_L) && (dst_base != src_base));
    assign w_desc      = !mode && (w_dist != '0) && ({1'b0, w_dist} < length);
    assign w_src_start = w_desc ? src_base + w_len_m1[ADDR_W-1:0] : src_base;
    assign w_dst_start = w_desc ? dst_base + w_len_m1[ADDR_W-1:0] : dst_base;
    assign w_step      = r_desc ? '1 : STEP_UP;
    assign w_wr_word   = r_mode ? r_fill : r_data_q;
    assign w_resume    = r_mode ? S_WRITE : S_READ;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: data_q is cleared too; it is a single datapath register, not a memory array.
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_desc    <= 1'b0;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_count   <= '0;
            r_fill    <= '0;
            r_data_q  <= '0;
            r_err     <= 1'b0;
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
            r_vaddr      <= '0;
            r_verify_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_valid) begin
                            r_mode    <= mode;
                            r_desc    <= w_desc;
                            r_src_ptr <= w_src_start;
                            r_dst_ptr <= w_dst_start;
                            r_count   <= length;
                            r_fill    <= fill_value;
                            r_err     <= 1'b0;
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
                            r_verify_err <= 1'b0;
`endif
                            r_state   <= mode ? S_WRITE : S_READ;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_data_q <= Read_Data_1;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    r_src_ptr <= r_src_ptr + w_step;
                    r_dst_ptr <= r_dst_ptr + w_step;
                    r_count   <= r_count - ONE_L;
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
                    r_vaddr   <= r_dst_ptr;
                    r_state   <= S_VERIFY;
`else
                    r_state   <= (r_count == ONE_L) ? S_DONE : w_resume;
`endif
                end
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
                S_VERIFY: begin
                    if (Read_Data_2 != w_wr_word) begin
                        r_verify_err <= 1'b1;
                    end
                    r_state <= (r_count == '0) ? S_DONE : w_resume;
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first, so no path through this block infers a latch.
    always_comb begin
        Read_Address_1 = '0;
        Write_Address  = '0;
        Write_Data     = '0;
        Write_Enable   = 1'b0;
        if (r_state == S_READ) begin
            Read_Address_1 = r_src_ptr;
        end
        if (r_state == S_WRITE) begin
            Write_Address = r_dst_ptr;
            Write_Data    = w_wr_word;
            Write_Enable  = reset;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign err  = r_err;

`ifdef RAM_BLOCK_MOVER_VERIFY_EN
    assign Read_Address_2 = (r_state == S_VERIFY) ? r_vaddr : '0;
    assign verify_err     = r_verify_err;
`endif

endmodule

// File: tb/tb_ram_block_mover.sv
// Self-checking bench for ram_block_mover: directed table, hand-written corner sequences and
// randomized requests checked against a row-level memory model.
module tb_ram_block_mover;

`ifdef RAM_BLOCK_MOVER_VERIFY_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [2:0]  src_base;
    logic [2:0]  dst_base;
    logic [3:0]  length;
    logic [10:0] fill_value;
    logic [10:0] Read_Data_1;
    logic [2:0]  Read_Address_1;
    logic [10:0] Write_Data;
    logic [2:0]  Write_Address;
    logic        Write_Enable;
    logic        busy;
    logic        done;
    logic        err;
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
    logic [10:0] Read_Data_2;
    logic [2:0]  Read_Address_2;
    logic        verify_err;
    logic        rd2_zero;
`endif

    ram_block_mover dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .src_base       (src_base),
        .dst_base       (dst_base),
        .length         (length),
        .fill_value     (fill_value),
        .Read_Data_1    (Read_Data_1),
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
        .Read_Data_2    (Read_Data_2),
        .Read_Address_2 (Read_Address_2),
        .verify_err     (verify_err),
`endif
        .Read_Address_1 (Read_Address_1),
        .Write_Data     (Write_Data),
        .Write_Address  (Write_Address),
        .Write_Enable   (Write_Enable),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: combinational reads, write on rising edge; pl_en loads a whole image.
    logic [10:0] ram    [8];
    logic [10:0] pl_img [8];
    logic [10:0] mdl    [8];
    logic        pl_en;
    int          we_count = 0;

    always @(posedge clk) begin
        if (pl_en) ram <= pl_img;
        else if (Write_Enable) ram[Write_Address] <= Write_Data;
        if (Write_Enable) we_count <= we_count + 1;
    end
    assign Read_Data_1 = ram[Read_Address_1];
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
    assign Read_Data_2 = rd2_zero ? 11'h000 : ram[Read_Address_2];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit req_valid(input bit m, input int s, input int d, input int len);
        return (len >= 1) && (len <= 8) && !(!m && len == 8 && s != d);
    endfunction

    // Apply the request row by row in the order the rules prescribe.
    task automatic model_apply(input bit m, input int s, input int d, input int len, input logic [10:0] fv);
        int  dd;
        bit  desc;
        dd   = (d - s + 8) % 8;
        desc = !m && dd != 0 && dd < len;
        for (int k = 0; k < len; k++) begin
            int i;
            i = desc ? len - 1 - k : k;
            mdl[(d + i) % 8] = m ? fv : mdl[(s + i) % 8];
        end
    endtask

    task automatic check_mem(input string tag);
        for (int r = 0; r < 8; r++)
            check($sformatf("%s row%0d", tag, r), 32'(ram[r]), 32'(mdl[r]));
    endtask

    task automatic preload();
        pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
        for (int r = 0; r < 8; r++) mdl[r] = pl_img[r];
    endtask

    // Caller is at a negedge. Returns the cycle (1 = first after acceptance) in which done was seen.
    task automatic run_op(input bit m, input logic [2:0] s, input logic [2:0] d, input logic [3:0] len,
                          input logic [10:0] fv, input int limit, output int lat, output int busy_low);
        mode = m; src_base = s; dst_base = d; length = len; fill_value = fv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        busy_low = 0;
        for (int k = 1; k <= limit; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_low++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input bit m, input logic [2:0] s, input logic [2:0] d, input logic [3:0] len,
                         input logic [10:0] fv, input bit exp_err, input string tag);
        int lat, blow, exp_lat, limit, we0;
        exp_lat = m ? (1 + V) * int'(len) + 1 : (2 + V) * int'(len) + 1;
        limit   = exp_err ? 6 : exp_lat + 4;
        we0     = we_count;
        run_op(m, s, d, len, fv, limit, lat, blow);
        if (!exp_err) begin
            check({tag, " done cycle"}, 32'(lat), 32'(exp_lat));
            check({tag, " busy before done"}, 32'(blow), 32'd0);
            check({tag, " busy in done"}, 32'(busy), 32'd1);
            @(negedge clk);
            check({tag, " done pulse width"}, 32'(done), 32'd0);
            check({tag, " busy after done"}, 32'(busy), 32'd0);
            model_apply(m, int'(s), int'(d), int'(len), fv);
            check({tag, " write count"}, 32'(we_count - we0), 32'(len));
        end else begin
            check({tag, " no done"}, 32'(lat), 32'hFFFF_FFFF);
            check({tag, " never busy"}, 32'(blow), 32'(limit));
            check({tag, " no write"}, 32'(we_count - we0), 32'd0);
        end
        check({tag, " err"}, 32'(err), 32'(exp_err));
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
        check({tag, " verify_err"}, 32'(verify_err), 32'd0);
`endif
        check_mem(tag);
    endtask

    typedef struct {
        bit          m;
        logic [2:0]  s;
        logic [2:0]  d;
        logic [3:0]  len;
        logic [10:0] fv;
        bit          exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int k;
        vecs[0] = '{1'b1, 3'd0, 3'd6, 4'd4, 11'h5A5, 1'b0};
        vecs[1] = '{1'b1, 3'd0, 3'd2, 4'd0, 11'h111, 1'b1};
        vecs[2] = '{1'b0, 3'd0, 3'd1, 4'd8, 11'h000, 1'b1};
        vecs[3] = '{1'b0, 3'd5, 3'd5, 4'd8, 11'h000, 1'b0};
        vecs[4] = '{1'b1, 3'd0, 3'd3, 4'd8, 11'h2D2, 1'b0};
        vecs[5] = '{1'b0, 3'd1, 3'd4, 4'd9, 11'h000, 1'b1};
        vecs[6] = '{1'b0, 3'd6, 3'd1, 4'd3, 11'h000, 1'b0};
        vecs[7] = '{1'b0, 3'd6, 3'd7, 4'd4, 11'h000, 1'b0};
        vecs[8] = '{1'b1, 3'd2, 3'd7, 4'd15, 11'h7FF, 1'b1};
        vecs[9] = '{1'b0, 3'd4, 3'd2, 4'd5, 11'h000, 1'b0};

        reset = 1'b0; start = 1'b0; mode = 1'b0; src_base = '0; dst_base = '0;
        length = '0; fill_value = '0; pl_en = 1'b0;
`ifdef RAM_BLOCK_MOVER_VERIFY_EN
        rd2_zero = 1'b0;
`endif
        for (int r = 0; r < 8; r++) pl_img[r] = 11'(r + 16);
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset we", 32'(Write_Enable), 32'd0);
        check("reset waddr", 32'(Write_Address), 32'd0);
        check("reset wdata", 32'(Write_Data), 32'd0);
        check("reset raddr1", 32'(Read_Address_1), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        preload();

        // Fill wrapping 6,7,0,1.
        do_op(1'b1, 3'd0, 3'd6, 4'd4, 11'h5A5, 1'b0, "fill_wrap");
        check("fill_wrap r6", 32'(ram[6]), 32'h5A5);
        check("fill_wrap r1", 32'(ram[1]), 32'h5A5);
        check("fill_wrap r2", 32'(ram[2]), 32'h012);

        // Overlapping copy forward: must run descending.
        for (int r = 0; r < 8; r++) pl_img[r] = (r < 6) ? 11'(r + 1) : 11'h0AA;
        preload();
        do_op(1'b0, 3'd0, 3'd2, 4'd4, 11'h000, 1'b0, "copy_desc");
        check("copy_desc r2", 32'(ram[2]), 32'd1);
        check("copy_desc r3", 32'(ram[3]), 32'd2);
        check("copy_desc r4", 32'(ram[4]), 32'd3);
        check("copy_desc r5", 32'(ram[5]), 32'd4);

        // Overlapping copy backward: ascending.
        pl_img[3] = 11'h7FF; pl_img[4] = 11'h001; pl_img[5] = 11'h400;
        preload();
        do_op(1'b0, 3'd3, 3'd1, 4'd3, 11'h000, 1'b0, "copy_asc");
        check("copy_asc r1", 32'(ram[1]), 32'h7FF);
        check("copy_asc r2", 32'(ram[2]), 32'h001);
        check("copy_asc r3", 32'(ram[3]), 32'h400);

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].m, vecs[i].s, vecs[i].d, vecs[i].len, vecs[i].fv, vecs[i].exp_err,
                  $sformatf("vec%0d", i));

        // Reset during the second WRITE of a 5-row fill.
        run_op(1'b1, 3'd0, 3'd2, 4'd5, 11'h3C3, 1, k, k);
        reset = 1'b0;
        @(negedge clk);
        check("rst_abort we", 32'(Write_Enable), 32'd0);
        check("rst_abort waddr", 32'(Write_Address), 32'd0);
        check("rst_abort wdata", 32'(Write_Data), 32'd0);
        check("rst_abort raddr1", 32'(Read_Address_1), 32'd0);
        check("rst_abort busy", 32'(busy), 32'd0);
        check("rst_abort done", 32'(done), 32'd0);
        mdl[2] = 11'h3C3;
        check_mem("rst_abort");
        reset = 1'b1;
        @(negedge clk);
        do_op(1'b0, 3'd7, 3'd5, 4'd3, 11'h000, 1'b0, "after_rst");

        // start held high through DONE relaunches only from the following IDLE cycle.
        mode = 1'b1; dst_base = 3'd4; length = 4'd2; fill_value = 11'h155; start = 1'b1;
        @(negedge clk);
        k = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("held done cycle", 32'(k), 32'((1 + V) * 2 + 1));
        @(negedge clk);
        check("held idle gap", 32'(busy), 32'd0);
        @(negedge clk);
        check("held relaunch busy", 32'(busy), 32'd1);
        check("held relaunch we", 32'(Write_Enable), 32'd1);
        start = 1'b0;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("held second done", 32'(done), 32'd1);
        @(negedge clk);
        mdl[4] = 11'h155; mdl[5] = 11'h155;
        check_mem("held");

`ifdef RAM_BLOCK_MOVER_VERIFY_EN
        rd2_zero = 1'b1;
        run_op(1'b1, 3'd0, 3'd0, 4'd3, 11'h123, 1, k, k);
        check("verify before", 32'(verify_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("verify flagged", 32'(verify_err), 32'd1);
        k = 3;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("verify done cycle", 32'(k), 32'd7);
        @(negedge clk);
        rd2_zero = 1'b0;
        for (int r = 0; r < 3; r++) mdl[r] = 11'h123;
        check_mem("verify");
`endif

        for (int t = 0; t < 40; t++) begin
            bit          m;
            logic [2:0]  s, d;
            logic [3:0]  len;
            if (t % 4 == 0) begin
                for (int r = 0; r < 8; r++) pl_img[r] = 11'($urandom);
                preload();
            end
            m   = 1'($urandom);
            s   = 3'($urandom);
            d   = (t % 3 == 0) ? s + 3'($urandom_range(1, 3)) : 3'($urandom);
            len = 4'($urandom_range(0, 9));
            do_op(m, s, d, len, 11'($urandom), !req_valid(m, int'(s), int'(d), int'(len)),
                  $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_block_mover.md
# ram_block_mover

Sequencing initiator for the 8×11-bit two-read/one-write RAM (`RAM_MxNbit`). It copies or fills a block of 1–8 rows and handles overlap like memmove. The block owns the RAM write port and read port 1, so the CPU datapath or a test harness issues one start pulse instead of driving addresses cycle by cycle. It sits between control logic and the RAM and connects directly to the RAM's port names and widths.

## Interface
Parameters:
- `DATA_W`, default 11: RAM word width.
- `ADDR_W`, default 3: RAM address width; depth is 2^ADDR_W = 8.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on rising edge of `clk`.
- `start` in 1: request pulse; accepted only in IDLE.
- `mode` in 1: 0 = copy, 1 = fill; sampled with `start`.
- `src_base` in ADDR_W: first source row (copy only).
- `dst_base` in ADDR_W: first destination row.
- `length` in ADDR_W+1: row count, valid range 1..8.
- `fill_value` in DATA_W: word written in fill mode.
- `Read_Data_1` in DATA_W: from RAM read port 1.
- `Read_Address_1` out ADDR_W: to RAM.
- `Write_Data` out DATA_W: to RAM.
- `Write_Address` out ADDR_W: to RAM.
- `Write_Enable` out 1: to RAM.
- `busy` out 1: high from the cycle after acceptance through DONE.
- `done` out 1: one-cycle pulse at completion.
- `err` out 1: sticky error; set on rejected request; cleared by the next accepted valid start.

## Operation
States and transitions:
- **IDLE**:
  - `start`=1 with valid request: latch `mode`, pointers, count and `fill_value`; go to READ (copy) or WRITE (fill).
  - Invalid request: set `err`, stay in IDLE, no RAM access.
  - `start` outside IDLE is ignored.
- **READ**:
  - `Read_Address_1` = src_ptr.
  - At edge: `data_q` ← `Read_Data_1`; go to WRITE.
- **WRITE**:
  - `Write_Enable`=1, `Write_Address`=dst_ptr, `Write_Data`=`data_q` (copy) or `fill_value` (fill).
  - At edge: step pointers, count−1.
  - count was 1 → DONE; otherwise → READ (copy) or WRITE (fill).
- **DONE**: `done`=1 for one cycle; go to IDLE.

Request validity:
- Invalid: `length`=0 or `length`>8.
- Also invalid: copy with `length`=8 and `dst_base`≠`src_base` (full-ring rotate cannot be done in place).

Direction and addressing:
- d = (`dst_base` − `src_base`) mod 8.
- Copy with 0<d<`length` runs descending: pointers start at base+`length`−1 and decrement.
- All other cases run ascending.
- Pointer arithmetic is mod 8; wrap 7→0 and 0→7 is legal.

Output defaults:
- Outputs are decoded from registered state and pointers (Moore).
- `Write_Enable`=0 outside WRITE.
- `Read_Address_1`, `Write_Address` and `Write_Data` are 0 in IDLE.
- `Write_Enable` is additionally gated by `reset`=1, so no RAM write happens on a reset edge.

## Timing
- Reset: state IDLE; `busy`, `done`, `err`, `Write_Enable` = 0; all addresses, `Write_Data` and `data_q` = 0.
- Reset asserted mid-operation aborts at that edge. Rows already written stay written; no `done` pulse.
- Start accepted at edge E:
  - Copy of N rows: `done` high in cycle E+2N+1.
  - Fill of N rows: `done` high in cycle E+N+1.
- `start` held high through DONE does not relaunch in that cycle; it is accepted in the following IDLE cycle.
- RAM read is combinational, so a row written at edge k is readable in the same cycle it is addressed after edge k.

## Configuration
- Macro: `RAM_BLOCK_MOVER_VERIFY_EN`.
- Defined:
  - Adds ports `Read_Address_2` out ADDR_W, `Read_Data_2` in DATA_W, and `verify_err` out 1 (reset 0).
  - Adds a VERIFY state after every WRITE: drive `Read_Address_2`=the dst_ptr just written, compare `Read_Data_2` to the written word.
  - A mismatch sets sticky `verify_err`, cleared by the next accepted start.
  - Latency: copy E+3N+1, fill E+2N+1.
- Undefined: those ports and the VERIFY state are absent; latency as in Timing.

## Test plan
- Fill, `dst_base`=6, `length`=4, `fill_value`=0x5A5: rows 6,7,0,1 = 0x5A5; other rows unchanged; `done` at E+5.
- Copy, `src_base`=0, `dst_base`=2, `length`=4, rows 0..5 = 1..6: descending run; rows 2..5 = 1,2,3,4; `done` at E+9.
- Copy, `src_base`=3, `dst_base`=1, `length`=3, rows 3..5 = 0x7FF,0x001,0x400: ascending run; rows 1..3 = 0x7FF,0x001,0x400.
- Invalid requests, `length`=0, then copy `length`=8 with `src_base`=0, `dst_base`=1: `err`=1, no `Write_Enable`, `busy`=0; next valid start clears `err`.
- `reset` low during the 2nd WRITE of a 5-row fill: no write on the reset edge; all outputs 0 next cycle; `start` one cycle after reset release is accepted normally.
- With `RAM_BLOCK_MOVER_VERIFY_EN`, force `Read_Data_2`=0x000 for a fill of 0x123: `verify_err`=1 after the first VERIFY cycle; the fill still completes with `done` at E+2N+1.
